// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] DEFAULT_DEVICE_ADDR = 7'h39;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_ACK,
        ST_WAIT
    } state_t;

endpackage

// File: rtl/i2c_reg_target_if.sv
// Pad and register-file signals of the I2C register target.
interface i2c_reg_target_if;
    import i2c_pkg::*;

    logic              SCL_IN;
    logic              SDA_IN;
    logic              SDA_OE;
    logic [BYTE_W-1:0] REG_ADDR;
    logic [BYTE_W-1:0] REG_WDATA;
    logic              REG_WE;
    logic              REG_RE;
    logic [BYTE_W-1:0] REG_RDATA;
    logic              BUSY;

    // Target side (the register target itself).
    modport slave (
        input  SCL_IN,
        input  SDA_IN,
        input  REG_RDATA,
        output SDA_OE,
        output REG_ADDR,
        output REG_WDATA,
        output REG_WE,
        output REG_RE,
        output BUSY
    );

    // Environment side (bus initiator plus register storage).
    modport master (
        output SCL_IN,
        output SDA_IN,
        output REG_RDATA,
        input  SDA_OE,
        input  REG_ADDR,
        input  REG_WDATA,
        input  REG_WE,
        input  REG_RE,
        input  BUSY
    );

endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus glitch filter for one open-drain line.
// The filtered level only changes after FILTER_LEN consecutive synchronized
// samples disagree with it; rise/fall pulse in the same cycle the level moves.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Metastability synchronizer; idles high like a pulled-up bus line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing samples; accept the new level on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            cnt   <= '0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                rise  <= sync2;
                fall  <= ~sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing an 8-bit-addressed register file (pointer, write, read).
module i2c_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEVICE_ADDR = DEFAULT_DEVICE_ADDR,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic           CLK_50MHZ,
    input  logic           RESET,
    i2c_reg_target_if.slave bus
);

    localparam int unsigned CNT_W = 4;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [BYTE_W-2:0] shift;
    logic [BYTE_W-1:0] ptr;
    logic [BYTE_W-1:0] wdata;
    logic              rw;
    logic              sda_oe;
    logic              reg_we;
    logic              reg_re;
    logic              busy;

    logic              scl_lvl;
    logic              scl_rise;
    logic              scl_fall;
    logic              sda_lvl;
    logic              sda_rise;
    logic              sda_fall;

    logic              start_c;
    logic              stop_c;
    logic [BYTE_W-1:0] rx_byte_c;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk   (CLK_50MHZ),
        .rst   (RESET),
        .raw   (bus.SCL_IN),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk   (CLK_50MHZ),
        .rst   (RESET),
        .raw   (bus.SDA_IN),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // Bus conditions and the byte completed by the current SCL rise.
    assign start_c   = sda_fall & scl_lvl;
    assign stop_c    = sda_rise & scl_lvl;
    assign rx_byte_c = {shift, sda_lvl};

    // Protocol engine: START/STOP first, then the SCL-rise / SCL-fall actions.
    always_ff @(posedge CLK_50MHZ or posedge RESET) begin
        if (RESET) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            ptr     <= '0;
            wdata   <= '0;
            rw      <= 1'b0;
            sda_oe  <= 1'b0;
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;

            // Pointer advances the cycle after a write strobe so REG_ADDR holds during it.
            if (reg_we) begin
                ptr <= ptr + BYTE_W'(1);
            end

            // Read data arrives the cycle after the strobe: load it and drive the MSB.
            if (reg_re) begin
                shift  <= bus.REG_RDATA[BYTE_W-2:0];
                sda_oe <= ~bus.REG_RDATA[BYTE_W-1];
                ptr    <= ptr + BYTE_W'(1);
            end

            if (start_c) begin
                state   <= ST_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_c) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    ST_ADDR, ST_PTR, ST_WR: begin
                        shift   <= rx_byte_c[BYTE_W-2:0];
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                            if (state == ST_ADDR) begin
                                if (rx_byte_c[BYTE_W-1:1] == DEVICE_ADDR) begin
                                    state <= ST_ADDR_ACK;
                                    busy  <= 1'b1;
                                    rw    <= rx_byte_c[0];
                                end else begin
                                    state <= ST_WAIT;
                                    busy  <= 1'b0;
                                end
                            end else if (state == ST_PTR) begin
                                ptr   <= rx_byte_c;
                                state <= ST_PTR_ACK;
                            end else begin
                                reg_we <= 1'b1;
                                wdata  <= rx_byte_c;
                                state  <= ST_WR_ACK;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                        bit_cnt <= CNT_W'(BYTE_W + 1);
                    end
                    ST_RD: begin
                        if (bit_cnt < CNT_W'(BYTE_W)) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    ST_RD_ACK: begin
                        if (sda_lvl == ACK) begin
                            state   <= ST_RD;
                            bit_cnt <= CNT_W'(BYTE_W + 1);
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                    default: begin
                    end
                endcase
            end else if (scl_fall) begin
                case (state)
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                        if (bit_cnt == CNT_W'(BYTE_W)) begin
                            sda_oe <= 1'b1;
                        end else if (bit_cnt == CNT_W'(BYTE_W + 1)) begin
                            bit_cnt <= '0;
                            if (state == ST_ADDR_ACK && rw) begin
                                // Keep SDA low until the first read bit replaces it.
                                state  <= ST_RD;
                                reg_re <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WR;
                            end
                        end
                    end
                    ST_RD: begin
                        if (bit_cnt == CNT_W'(BYTE_W + 1)) begin
                            reg_re  <= 1'b1;
                            bit_cnt <= '0;
                        end else if (bit_cnt == CNT_W'(BYTE_W)) begin
                            sda_oe <= 1'b0;
                            state  <= ST_RD_ACK;
                        end else if (bit_cnt != '0) begin
                            shift  <= {shift[BYTE_W-3:0], NACK};
                            sda_oe <= ~shift[BYTE_W-2];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.SDA_OE    = sda_oe;
    assign bus.REG_ADDR  = ptr;
    assign bus.REG_WDATA = wdata;
    assign bus.REG_WE    = reg_we;
    assign bus.REG_RE    = reg_re;
    assign bus.BUSY      = busy;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: table of write transactions plus
// hand-written read, glitch and reset-during-ACK sequences.
module tb_i2c_reg_target;
    import i2c_pkg::*;

    localparam int unsigned Q = 16;   // clocks per quarter SCL period

    logic clk = 1'b0;
    logic rst;
    logic scl_m;
    logic sda_m;

    int checks = 0;
    int errors = 0;

    i2c_reg_target_if bus ();

    i2c_reg_target #(.DEVICE_ADDR(7'h39), .FILTER_LEN(3)) dut (
        .CLK_50MHZ (clk),
        .RESET     (rst),
        .bus       (bus)
    );

    always #10 clk = ~clk;

    // Open-drain wiring and a register file returning ~address with 1-cycle latency.
    assign bus.SCL_IN = scl_m;
    assign bus.SDA_IN = sda_m & ~bus.SDA_OE;
    always_ff @(posedge clk) bus.REG_RDATA <= ~bus.REG_ADDR;

    // Strobe monitor.
    logic [15:0] wr_log[$];
    int re_count   = 0;
    int oe_cycles  = 0;
    int width_errs = 0;
    logic we_d = 1'b0;
    logic re_d = 1'b0;
    always @(negedge clk) begin
        if (bus.REG_WE) wr_log.push_back({bus.REG_ADDR, bus.REG_WDATA});
        if (bus.REG_RE) re_count <= re_count + 1;
        if (bus.SDA_OE) oe_cycles <= oe_cycles + 1;
        if ((bus.REG_WE && we_d) || (bus.REG_RE && re_d)) width_errs <= width_errs + 1;
        we_d <= bus.REG_WE;
        re_d <= bus.REG_RE;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int glitch_bit);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i];
            tick(Q);
            if (i == glitch_bit) begin
                scl_m = 1'b1; tick(2);
                scl_m = 1'b0; tick(Q);
            end
            scl_m = 1'b1; tick(2 * Q);
            scl_m = 1'b0; tick(Q);
        end
    endtask

    task automatic ack_cycle(output logic ack);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        ack = bus.SDA_IN; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        send_bits(b, glitch_bit);
        ack_cycle(ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        b = 8'h00;
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(Q);
            scl_m = 1'b1; tick(Q);
            b = {b[6:0], bus.SDA_IN}; tick(Q);
            scl_m = 1'b0;
        end
        tick(Q);
        sda_m = master_ack; tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
        sda_m = 1'b1;
    endtask

    typedef struct packed {
        logic [7:0]  addr_byte;
        logic [7:0]  ptr;
        logic [1:0]  n;
        logic [23:0] data;      // first data byte in [23:16]
        logic        acked;
    } wvec_t;

    wvec_t      vecs[4];
    logic       ack;
    logic       exp_ack;
    logic [7:0] d;
    logic [7:0] rb;
    int         wbase;
    int         oebase;
    int         rebase;

    initial begin
        vecs[0] = '{8'h72, 8'h98, 2'd1, 24'h03_00_00, 1'b1};
        vecs[1] = '{8'h72, 8'hFE, 2'd3, 24'h11_22_33, 1'b1};
        vecs[2] = '{8'h74, 8'h98, 2'd1, 24'h55_00_00, 1'b0};
        vecs[3] = '{8'h72, 8'h10, 2'd2, 24'hA5_5A_00, 1'b1};

        rst   = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(5);
        check("rst_sda_oe", bus.SDA_OE, 0);
        check("rst_reg_addr", bus.REG_ADDR, 8'h00);
        check("rst_reg_wdata", bus.REG_WDATA, 8'h00);
        check("rst_reg_we", bus.REG_WE, 0);
        check("rst_reg_re", bus.REG_RE, 0);
        check("rst_busy", bus.BUSY, 0);
        rst = 1'b0;
        tick(10);

        // Table-driven write transactions.
        for (int v = 0; v < 4; v++) begin
            wbase   = wr_log.size();
            oebase  = oe_cycles;
            exp_ack = vecs[v].acked ? ACK : NACK;
            bus_start();
            write_byte(vecs[v].addr_byte, -1, ack);
            check($sformatf("v%0d_addr_ack", v), ack, exp_ack);
            check($sformatf("v%0d_busy", v), bus.BUSY, vecs[v].acked);
            write_byte(vecs[v].ptr, -1, ack);
            check($sformatf("v%0d_ptr_ack", v), ack, exp_ack);
            for (int k = 0; k < int'(vecs[v].n); k++) begin
                d = vecs[v].data[23 - 8 * k -: 8];
                write_byte(d, -1, ack);
                check($sformatf("v%0d_data%0d_ack", v, k), ack, exp_ack);
            end
            bus_stop();
            tick(8);
            check($sformatf("v%0d_busy_after_stop", v), bus.BUSY, 0);
            check($sformatf("v%0d_we_count", v), wr_log.size() - wbase,
                  vecs[v].acked ? int'(vecs[v].n) : 0);
            if (vecs[v].acked) begin
                for (int k = 0; k < int'(vecs[v].n); k++) begin
                    d = vecs[v].data[23 - 8 * k -: 8];
                    check($sformatf("v%0d_we%0d", v, k), wr_log[wbase + k],
                          {8'(vecs[v].ptr + k), d});
                end
            end else begin
                check($sformatf("v%0d_sda_never_driven", v), oe_cycles - oebase, 0);
            end
        end

        // Pointer write, repeated START, two-byte read (ACK then NACK).
        wbase = wr_log.size();
        bus_start();
        write_byte(8'h72, -1, ack);
        check("rd_addw_ack", ack, ACK);
        write_byte(8'h41, -1, ack);
        check("rd_ptr_ack", ack, ACK);
        rebase = re_count;
        bus_start();
        write_byte(8'h73, -1, ack);
        check("rd_addr_ack", ack, ACK);
        read_byte(ACK, rb);
        check("rd_byte0", rb, 8'hBE);
        read_byte(NACK, rb);
        check("rd_byte1", rb, 8'hBD);
        tick(Q);
        check("rd_sda_released", bus.SDA_OE, 0);
        check("rd_re_count", re_count - rebase, 2);
        check("rd_no_we", wr_log.size() - wbase, 0);
        bus_stop();
        tick(8);
        check("rd_busy_after_stop", bus.BUSY, 0);
        check("rd_ptr_after", bus.REG_ADDR, 8'h43);

        // Short SCL glitches inside the pointer and data bytes.
        wbase = wr_log.size();
        bus_start();
        write_byte(8'h72, -1, ack);
        check("gl_addr_ack", ack, ACK);
        write_byte(8'h20, 3, ack);
        check("gl_ptr_ack", ack, ACK);
        write_byte(8'h6C, 5, ack);
        check("gl_data_ack", ack, ACK);
        bus_stop();
        tick(8);
        check("gl_we_count", wr_log.size() - wbase, 1);
        check("gl_we", wr_log[wbase], 16'h206C);
        check("gl_ptr_after", bus.REG_ADDR, 8'h21);

        // Reset while the target is driving the address ACK.
        bus_start();
        send_bits(8'h72, -1);
        check("rs_ack_driven", bus.SDA_OE, 1);
        #3 rst = 1'b1;
        #1;
        check("rs_sda_oe", bus.SDA_OE, 0);
        check("rs_reg_addr", bus.REG_ADDR, 8'h00);
        check("rs_busy", bus.BUSY, 0);
        tick(3);
        rst = 1'b0;
        sda_m = 1'b1;
        tick(Q);
        bus_stop();
        tick(8);
        wbase = wr_log.size();
        bus_start();
        write_byte(8'h72, -1, ack);
        check("rs_addr_ack", ack, ACK);
        write_byte(8'h07, -1, ack);
        check("rs_ptr_ack", ack, ACK);
        write_byte(8'h99, -1, ack);
        check("rs_data_ack", ack, ACK);
        bus_stop();
        tick(8);
        check("rs_we_count", wr_log.size() - wbase, 1);
        check("rs_we", wr_log[wbase], 16'h0799);
        check("rs_busy_after_stop", bus.BUSY, 0);

        check("strobe_width", width_errs, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
